// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the fetch stage
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'hF000_0000;
  localparam logic [7:0]  R_RET         = 8'd253;
  localparam logic [7:0]  MOVL_OPC      = 8'h1C;
  localparam int          RAS_MAX_DEPTH = 32;

  // Checkpoint sized for the deepest legal stack; narrower builds zero-extend.
  typedef struct packed {
    logic [5:0] count;
    logic [4:0] ptr;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - speculative return-address stack with checkpoint restore
//
// Ports:
//   clock, reset            clock, asynchronous active-low reset
//   push, pop, restore      one operation per cycle, restore has priority
//   restore_count/_ptr      checkpoint loaded on restore
//   push_data               return address written at ptr+1
//   top                     entry at ptr
//   count, ptr              current occupancy and top-of-stack index
module ras_stack #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 15,
  localparam int RP_W  = $clog2(DEPTH),
  localparam int RC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              restore,
  input  logic [RC_W-1:0]   restore_count,
  input  logic [RP_W-1:0]   restore_ptr,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic [RC_W-1:0]   count,
  output logic [RP_W-1:0]   ptr
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RP_W-1:0]   ptr_inc;
  logic [RP_W-1:0]   ptr_dec;

  assign ptr_inc = ptr + RP_W'(1);
  assign ptr_dec = ptr - RP_W'(1);
  assign top     = mem[ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (restore) begin
      // Only the pointers roll back; entries keep whatever was pushed since.
      count <= restore_count;
      ptr   <= restore_ptr;
    end else if (push) begin
      // When full, ptr_inc lands on the oldest entry and overwrites it.
      mem[ptr_inc] <= push_data;
      ptr          <= ptr_inc;
      if (count != RC_W'(DEPTH)) count <= count + RC_W'(1);
    end else if (pop && count != '0) begin
      ptr   <= ptr_dec;
      count <= count - RC_W'(1);
    end
  end

endmodule

// File: rtl/fetch_ras_unit.sv
// rtl/fetch_ras_unit.sv - instruction fetch with jump/branch/return prediction
//
// Optional macro FETCH_BIMODAL_EN: bimodal 2-bit counter branch predictor
// trained by rslt_*; without it branches are predicted taken iff instr[26].
//
// Ports:
//   clock, reset        clock, asynchronous active-low reset
//   stall               hold pc and RAS
//   flush_en/pc/ckpt    redirect and RAS {count, ptr} restore
//   rslt_en/pc/taken    resolved branch feedback
//   imem_addr           next fetch address (new_pc)
//   imem_instr          instruction at pc
//   instr_out           instruction to decode (calls rewritten, jumps squashed)
//   pc_out              current pc
//   approx_out          predicted-taken control transfer
//   pred_target_out     predicted target, 0 when not predicted
//   ras_ckpt_out        RAS {count, ptr} before this instruction's push/pop
module fetch_ras_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W       = 15,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              RAS_DEPTH  = 8,
  parameter logic [7:0]      RET_OPCODE = 8'hE4,
  parameter int              BHT_BITS   = 8,
  localparam int             RP_W       = $clog2(RAS_DEPTH),
  localparam int             RC_W       = $clog2(RAS_DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush_en,
  input  logic [PC_W-1:0]      flush_pc,
  input  logic [RC_W+RP_W-1:0] flush_ckpt,
  input  logic                 rslt_en,
  input  logic [PC_W-1:0]      rslt_pc,
  input  logic                 rslt_taken,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          instr_out,
  output logic [PC_W-1:0]      pc_out,
  output logic                 approx_out,
  output logic [PC_W-1:0]      pred_target_out,
  output logic [RC_W+RP_W-1:0] ras_ckpt_out
);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] new_pc;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] br_tgt;
  logic [15:0]     br_off;
  logic [PC_W-1:0] ras_top;
  logic [RC_W-1:0] ras_count;
  logic [RP_W-1:0] ras_ptr;
  logic [PC_W-1:0] pred_tgt;
  logic            pred;
  logic            is_jump, is_call, is_ret, is_branch;
  logic            ret_hit, br_taken;
  logic            unused_ok;
  ras_ckpt_t       cur_ckpt;

  assign pc_plus1 = pc + PC_W'(1);
  assign jump_tgt = pc + imem_instr[8 +: PC_W];
  assign br_off   = {{5{imem_instr[26]}}, imem_instr[26:16]};
  assign br_tgt   = pc + br_off[PC_W-1:0];

  assign is_jump   = imem_instr[31] & imem_instr[30] & imem_instr[29] & imem_instr[27];
  assign is_call   = is_jump & imem_instr[24];
  // A word that also decodes as a jump is handled as the jump.
  assign is_ret    = (imem_instr[31:24] == RET_OPCODE) & ~is_jump;
  assign is_branch = imem_instr[31] & ~imem_instr[30];
  assign ret_hit   = is_ret & (ras_count != '0);

`ifdef FETCH_BIMODAL_EN
  logic [1:0] bht [2**BHT_BITS];
  logic [BHT_BITS-1:0] wr_idx;

  assign wr_idx   = rslt_pc[BHT_BITS-1:0];
  assign br_taken = bht[pc[BHT_BITS-1:0]][1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**BHT_BITS; i++) bht[i] <= 2'b01;
    end else if (rslt_en) begin
      if (rslt_taken && bht[wr_idx] != 2'b11)
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      else if (!rslt_taken && bht[wr_idx] != 2'b00)
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
    end
  end

  assign unused_ok = ^{cur_ckpt, rslt_pc};
`else
  // Static backward-taken prediction: offset sign bit.
  assign br_taken  = imem_instr[26];
  assign unused_ok = ^{cur_ckpt, rslt_en, rslt_pc, rslt_taken, BHT_BITS};
`endif

  always_comb begin
    pred     = 1'b0;
    pred_tgt = '0;
    if (is_jump) begin
      pred     = 1'b1;
      pred_tgt = jump_tgt;
    end else if (ret_hit) begin
      pred     = 1'b1;
      pred_tgt = ras_top;
    end else if (is_branch && br_taken) begin
      pred     = 1'b1;
      pred_tgt = br_tgt;
    end
  end

  always_comb begin
    new_pc = pc_plus1;
    if (flush_en)   new_pc = flush_pc;
    else if (stall) new_pc = pc;
    else if (pred)  new_pc = pred_tgt;
  end

  always_comb begin
    instr_out = imem_instr;
    if (!reset || flush_en) instr_out = NOP_INSTR;
    else if (is_call)       instr_out = {MOVL_OPC, 16'(pc_plus1), R_RET};
    else if (is_jump)       instr_out = NOP_INSTR;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= new_pc;
  end

  ras_stack #(
    .DEPTH  (RAS_DEPTH),
    .DATA_W (PC_W)
  ) u_ras (
    .clock         (clock),
    .reset         (reset),
    .push          (is_call & ~stall & ~flush_en),
    .pop           (ret_hit & ~stall & ~flush_en),
    .restore       (flush_en),
    .restore_count (flush_ckpt[RP_W +: RC_W]),
    .restore_ptr   (flush_ckpt[RP_W-1:0]),
    .push_data     (pc_plus1),
    .top           (ras_top),
    .count         (ras_count),
    .ptr           (ras_ptr)
  );

  assign cur_ckpt = '{count: 6'(ras_count), ptr: 5'(ras_ptr)};

  assign imem_addr       = reset ? new_pc : RESET_PC;
  assign pc_out          = pc;
  assign approx_out      = reset & pred;
  assign pred_target_out = reset ? pred_tgt : '0;
  assign ras_ckpt_out    = reset ? {cur_ckpt.count[RC_W-1:0], cur_ckpt.ptr[RP_W-1:0]} : '0;

endmodule

// File: tb/tb_fetch_ras_unit.sv
// tb/tb_fetch_ras_unit.sv - scoreboard bench for fetch_ras_unit
module tb_fetch_ras_unit;

  localparam int MASK  = 32'h7FFF;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP   = 32'hF000_0000;
  localparam logic [31:0] PLAIN = 32'h0000_0000;
  localparam logic [31:0] RET   = 32'hE400_0000;
  localparam logic [31:0] CALL  = 32'hE900_1000;
  localparam logic [31:0] BWD   = 32'h87F0_0000;
  localparam logic [31:0] FWD   = 32'h8010_0000;

  logic        clock;
  logic        reset;
  logic        stall, flush_en, rslt_en, rslt_taken;
  logic [14:0] flush_pc, rslt_pc;
  logic [6:0]  flush_ckpt;
  logic [14:0] imem_addr, pc_out, pred_target_out;
  logic [31:0] imem_instr, instr_out;
  logic        approx_out;
  logic [6:0]  ras_ckpt_out;

  fetch_ras_unit #(
    .PC_W(15), .RESET_PC(15'd0), .RAS_DEPTH(8), .RET_OPCODE(8'hE4), .BHT_BITS(8)
  ) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .flush_en(flush_en), .flush_pc(flush_pc), .flush_ckpt(flush_ckpt),
    .rslt_en(rslt_en), .rslt_pc(rslt_pc), .rslt_taken(rslt_taken),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .instr_out(instr_out),
    .pc_out(pc_out), .approx_out(approx_out), .pred_target_out(pred_target_out),
    .ras_ckpt_out(ras_ckpt_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] approx;
    logic [31:0] tgt;
    logic [31:0] ck;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int m_pc, m_cnt, m_ptr;
  int m_ras [DEPTH];
  int m_bht [256];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr", 32'(imem_addr), e.addr);
      chk("instr_out", instr_out, e.instr);
      chk("pc_out", 32'(pc_out), e.pc);
      chk("approx_out", 32'(approx_out), e.approx);
      chk("pred_target_out", 32'(pred_target_out), e.tgt);
      chk("ras_ckpt_out", 32'(ras_ckpt_out), e.ck);
    end
  end

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_ptr = 0;
    foreach (m_ras[i]) m_ras[i] = 0;
    foreach (m_bht[i]) m_bht[i] = 1;
  endtask

  // Called just after a rising edge; leaves the bench just after the next one.
  task automatic do_reset(input int cycles);
    exp_t e;
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < cycles; c++) begin
      imem_instr = $urandom;
      e = '{32'd0, NOP, 32'd0, 32'd0, 32'd0, 32'd0};
      exp_q.push_back(e);
      @(posedge clock); #1;
    end
    reset = 1'b1;
  endtask

  task automatic step(input logic [31:0] ins, input logic st, input logic fl,
                      input logic [14:0] fpc, input logic [6:0] fck,
                      input logic re, input logic [14:0] rpc, input logic rt);
    exp_t e;
    bit jump, call, ret, br, taken, pr;
    int tgt, npc, off;
    imem_instr = ins; stall = st; flush_en = fl; flush_pc = fpc; flush_ckpt = fck;
    rslt_en = re; rslt_pc = rpc; rslt_taken = rt;

    jump = ins[31] && ins[30] && ins[29] && ins[27];
    call = jump && ins[24];
    ret  = !jump && ins[31:24] == 8'hE4;
    br   = ins[31] && !ins[30];
`ifdef FETCH_BIMODAL_EN
    taken = m_bht[m_pc & 255] >= 2;
`else
    taken = ins[26];
`endif
    off = int'(ins[26:16]);
    if (ins[26]) off -= 2048;
    pr = 1; tgt = 0;
    if (jump)                tgt = (m_pc + int'(ins[23:8])) & MASK;
    else if (ret && m_cnt>0) tgt = m_ras[m_ptr];
    else if (br && taken)    tgt = (m_pc + off) & MASK;
    else                     pr = 0;

    if (fl)      npc = fpc;
    else if (st) npc = m_pc;
    else if (pr) npc = tgt;
    else         npc = (m_pc + 1) & MASK;

    e.addr   = npc;
    e.pc     = m_pc;
    e.approx = pr;
    e.tgt    = tgt;
    e.ck     = (m_cnt << 3) | m_ptr;
    if (fl)        e.instr = NOP;
    else if (call) e.instr = {8'h1C, 16'((m_pc + 1) & MASK), 8'd253};
    else if (jump) e.instr = NOP;
    else           e.instr = ins;
    exp_q.push_back(e);

    if (fl) begin
      m_cnt = int'(fck[6:3]);
      m_ptr = int'(fck[2:0]);
    end else if (!st) begin
      if (call) begin
        m_ptr = (m_ptr + 1) % DEPTH;
        m_ras[m_ptr] = (m_pc + 1) & MASK;
        if (m_cnt < DEPTH) m_cnt++;
      end else if (ret && m_cnt > 0) begin
        m_ptr = (m_ptr + DEPTH - 1) % DEPTH;
        m_cnt--;
      end
    end
`ifdef FETCH_BIMODAL_EN
    if (re) begin
      if (rt && m_bht[rpc & 255] < 3) m_bht[rpc & 255]++;
      else if (!rt && m_bht[rpc & 255] > 0) m_bht[rpc & 255]--;
    end
`endif
    m_pc = npc;
    @(posedge clock); #1;
  endtask

  task automatic run(input logic [31:0] ins);
    step(ins, 1'b0, 1'b0, 15'd0, 7'd0, 1'b0, 15'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: r[31] = 1'b0;
      3, 4, 5: begin
        {r[31], r[30], r[29], r[27]} = 4'hF;
        r[24] = ($urandom_range(0, 2) != 0);
      end
      6, 7:    r[31:24] = 8'hE4;
      default: begin r[31] = 1'b1; r[30] = 1'b0; end
    endcase
    return r;
  endfunction

  initial begin
    reset = 1'b1; stall = 0; flush_en = 0; flush_pc = 0; flush_ckpt = 0;
    rslt_en = 0; rslt_pc = 0; rslt_taken = 0; imem_instr = PLAIN;
    @(posedge clock); #1;
    do_reset(3);

    for (int i = 0; i < 5; i++) run(PLAIN);
    run(CALL);
    run(RET);

    for (int i = 0; i < 9; i++) run(CALL);
    for (int i = 0; i < 9; i++) run(RET);

    run(CALL);
    step(CALL, 1'b0, 1'b1, 15'h40, 7'd0, 1'b0, 15'd0, 1'b0);

    run(CALL);
    for (int i = 0; i < 3; i++) step(RET, 1'b1, 1'b0, 15'd0, 7'd0, 1'b0, 15'd0, 1'b0);
    run(RET);

    run(BWD);
    run(FWD);

    step(PLAIN, 1'b0, 1'b1, 15'h20, 7'd0, 1'b1, 15'h20, 1'b1);
    step(PLAIN, 1'b0, 1'b1, 15'h20, 7'd0, 1'b1, 15'h20, 1'b1);
    run(FWD);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        step(rand_instr(),
             $urandom_range(0, 5) == 0,
             $urandom_range(0, 15) == 0,
             15'($urandom),
             {4'($urandom_range(0, 8)), 3'($urandom_range(0, 7))},
             1'($urandom),
             15'($urandom_range(0, 63)),
             1'($urandom));
      end
    end

    @(negedge clock);
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
